// File: rtl/beta_mem_pkg.sv
// Shared encodings for the Beta core instruction/data memory arbiter.
package beta_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      GNT_FETCH = 1'b0,
      GNT_DATA  = 1'b1
   } grant_e;

   localparam int DEFAULT_TIMEOUT_CYCLES = 255;

   // Ack-wait counter width: wide enough to reach the limit, never below 8 bits.
   function automatic int timeout_cnt_w(input int limit);
      return ($clog2(limit + 1) > 8) ? $clog2(limit + 1) : 8;
   endfunction

endpackage

// File: rtl/beta_mem_arbiter.sv
// Arbitrates the Beta fetch and data ports onto one single-port word memory.
// Optional ack-wait timeout with bus_err pulse is enabled by defining ARB_TIMEOUT_EN.
module beta_mem_arbiter
   import beta_mem_pkg::*;
#(
   parameter int ADDR_W         = 16,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              RESET_N,
   input  logic              i_req,
   input  logic [31:0]       i_adr,
   output logic [31:0]       i_rdata,
   output logic              i_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [31:0]       d_adr,
   input  logic [31:0]       d_wdata,
   output logic [31:0]       d_rdata,
   output logic              d_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              bus_err
);

   arb_state_e        state_q, state_d;
   grant_e            last_q, last_d;
   grant_e            gnt_q, gnt_d;
   grant_e            win;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       i_rdata_q, i_rdata_d;
   logic [31:0]       d_rdata_q, d_rdata_d;
   logic [31:0]       resp_data;
   logic              timeout_hit;

   // Byte-address bits outside the word-address window are dropped by design.
   logic unused_adr_bits;
   assign unused_adr_bits = ^{i_adr[1:0], i_adr[31:ADDR_W+2], d_adr[1:0], d_adr[31:ADDR_W+2]};

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   assign timeout_hit = !mem_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES > 0);
   assign timeout_hit    = 1'b0;
`endif

   // Both pending: serve the port that did not win last time.
   always_comb begin
      if (i_req && d_req) win = (last_q == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
      else if (d_req)     win = GNT_DATA;
      else                win = GNT_FETCH;
   end

   // NOTE: the data-path registers are small flops, not RAM, so they take the
   // async reset too; that is what makes every output read 0 during reset.
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= IDLE;
         last_q    <= GNT_FETCH;
         gnt_q     <= GNT_FETCH;
         we_q      <= 1'b0;
         adr_q     <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of the others.
         state_q   <= state_d;
         last_q    <= last_d;
         gnt_q     <= gnt_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign resp_data = mem_ack ? mem_rdata : 32'h0;

   always_comb begin
      // NOTE: hold-value defaults first, so no path through this block infers a latch.
      state_d   = state_q;
      last_d    = last_q;
      gnt_d     = gnt_q;
      we_d      = we_q;
      adr_d     = adr_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               gnt_d   = win;
               last_d  = win;
               state_d = ACCESS;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
               err_d   = 1'b0;
`endif
               if (win == GNT_DATA) begin
                  we_d    = d_we;
                  adr_d   = d_adr[ADDR_W+1:2];
                  wdata_d = d_wdata;
               end else begin
                  we_d    = 1'b0;
                  adr_d   = i_adr[ADDR_W+1:2];
                  wdata_d = 32'h0;
               end
            end
         end
         ACCESS: begin
            if (mem_ack || timeout_hit) begin
               state_d = RESP;
               if (gnt_q == GNT_DATA) d_rdata_d = resp_data;
               else                   i_rdata_d = resp_data;
`ifdef ARB_TIMEOUT_EN
               err_d = timeout_hit;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_req = (state_q == ACCESS);
      i_ready = (state_q == RESP) && (gnt_q == GNT_FETCH);
      d_ready = (state_q == RESP) && (gnt_q == GNT_DATA);
`ifdef ARB_TIMEOUT_EN
      bus_err = (state_q == RESP) && err_q;
`else
      bus_err = 1'b0;
`endif
   end

   assign mem_we    = we_q;
   assign mem_adr   = adr_q;
   assign mem_wdata = wdata_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Randomized self-checking bench for beta_mem_arbiter against a transaction-level model.
// With ARB_TIMEOUT_EN defined the DUT is built with a 4-cycle timeout and that path is exercised.
module tb_beta_mem_arbiter;

   localparam int ADDR_W = 16;
`ifdef ARB_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic              clk = 1'b0;
   logic              RESET_N;
   logic              i_req, d_req, d_we;
   logic [31:0]       i_adr, d_adr, d_wdata;
   logic [31:0]       i_rdata, d_rdata;
   logic              i_ready, d_ready;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_adr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata = 32'h0;
   logic              mem_ack = 1'b0;
   logic              bus_err;

   beta_mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .RESET_N(RESET_N),
      .i_req(i_req), .i_adr(i_adr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Memory responder: random or forced wait states, one-cycle ack, garbage rdata otherwise.
   logic [31:0] mem_store [256];
   int force_wait = -1;
   int wait_left  = 0;
   int last_wait  = 0;
   bit busy       = 1'b0;

   always @(negedge clk) begin
      if (!RESET_N) begin
         mem_ack = 1'b0;
         busy    = 1'b0;
      end else if (mem_ack) begin
         mem_ack   = 1'b0;
         busy      = 1'b0;
         mem_rdata = $urandom;
      end else if (mem_req) begin
         if (!busy) begin
            busy      = 1'b1;
            wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 2));
            last_wait = wait_left;
         end
         if (wait_left == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_store[mem_adr[7:0]];
            if (mem_we) mem_store[mem_adr[7:0]] = mem_wdata;
         end else begin
            wait_left--;
            mem_rdata = $urandom;
         end
      end else begin
         busy      = 1'b0;
         mem_rdata = $urandom;
      end
   end

   // Reference model: word-indexed memory image, alternation memory, per-port rdata.
   logic [31:0] ref_mem [256];
   bit          model_last = 1'b0;
   logic [31:0] exp_i_rdata = 32'h0;
   logic [31:0] exp_d_rdata = 32'h0;
   int          req_wait_cycles = 0;

   task automatic do_access(input bit is_data, input logic [31:0] adr, input bit we,
                            input logic [31:0] wd, input bit raise_other, input bit expect_to);
      int          n;
      bit          seen;
      logic [7:0]  w;
      logic [31:0] exp_rd;
      w    = adr[9:2];
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         seen = mem_req;
      end
      req_wait_cycles = n;
      check("mem_req_seen", 32'(seen), 32'd1);
      check("mem_adr", 32'(mem_adr), 32'(adr[17:2]));
      check("mem_we", 32'(mem_we), 32'(is_data & we));
      check("mem_wdata", mem_wdata, is_data ? wd : 32'h0);
      if (raise_other) begin
         if (is_data) i_req = 1'b1;
         else         d_req = 1'b1;
      end
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         seen = i_ready | d_ready;
      end
      check("ready_seen", 32'(seen), 32'd1);
      check("ready_latency", 32'(n), expect_to ? 32'(TO) : 32'(last_wait + 1));
      if (expect_to) exp_rd = 32'h0;
      else begin
         exp_rd = ref_mem[w];
         if (is_data && we) ref_mem[w] = wd;
      end
      if (is_data) exp_d_rdata = exp_rd;
      else         exp_i_rdata = exp_rd;
      model_last = is_data;
      check("i_ready", 32'(i_ready), 32'(!is_data));
      check("d_ready", 32'(d_ready), 32'(is_data));
      check("i_rdata", i_rdata, exp_i_rdata);
      check("d_rdata", d_rdata, exp_d_rdata);
      check("bus_err", 32'(bus_err), 32'(expect_to));
      if (is_data) d_req = 1'b0;
      else         i_req = 1'b0;
      @(negedge clk);
      check("ready_one_cycle", 32'({i_ready, d_ready}), 32'd0);
      check("bus_err_one_cycle", 32'(bus_err), 32'd0);
   endtask

   // kind: 0 fetch only, 1 data only, 2 both together, 3 fetch then data mid-access, 4 data then fetch
   task automatic round(input int kind);
      logic [31:0] ia, da, dw;
      bit          dwe, first;
      ia = $urandom; da = $urandom; dw = $urandom; dwe = 1'($urandom_range(0, 1));
      i_adr = ia; d_adr = da; d_wdata = dw; d_we = dwe;
      case (kind)
         0: begin i_req = 1'b1; do_access(1'b0, ia, 1'b0, 32'h0, 1'b0, 1'b0); end
         1: begin d_req = 1'b1; do_access(1'b1, da, dwe, dw, 1'b0, 1'b0); end
         2: begin
            i_req = 1'b1; d_req = 1'b1;
            first = !model_last;
            if (first) begin
               do_access(1'b1, da, dwe, dw, 1'b0, 1'b0);
               do_access(1'b0, ia, 1'b0, 32'h0, 1'b0, 1'b0);
            end else begin
               do_access(1'b0, ia, 1'b0, 32'h0, 1'b0, 1'b0);
               do_access(1'b1, da, dwe, dw, 1'b0, 1'b0);
            end
         end
         3: begin
            i_req = 1'b1;
            do_access(1'b0, ia, 1'b0, 32'h0, 1'b1, 1'b0);
            do_access(1'b1, da, dwe, dw, 1'b0, 1'b0);
         end
         default: begin
            d_req = 1'b1;
            do_access(1'b1, da, dwe, dw, 1'b1, 1'b0);
            do_access(1'b0, ia, 1'b0, 32'h0, 1'b0, 1'b0);
         end
      endcase
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      RESET_N = 1'b0;
      @(negedge clk);
      RESET_N     = 1'b1;
      model_last  = 1'b0;
      exp_i_rdata = 32'h0;
      exp_d_rdata = 32'h0;
   endtask

   initial begin
      logic [31:0] v;
      bit          seen;
      RESET_N = 1'b0;
      i_req = 1'b1; i_adr = 32'h8000_0000;
      d_req = 1'b0; d_we = 1'b0; d_adr = 32'h0; d_wdata = 32'h0;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         mem_store[i] = v;
         ref_mem[i]   = v;
      end

      // Reset holds every output at 0 even with a request pending.
      repeat (3) @(negedge clk);
      check("rst_ctrl", 32'({i_ready, d_ready, mem_req, mem_we, bus_err}), 32'd0);
      check("rst_mem_adr", 32'(mem_adr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_i_rdata", i_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
      RESET_N = 1'b1;
      do_access(1'b0, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 1'b0);
      check("rst_first_req_latency", 32'(req_wait_cycles), 32'd1);

      // Single fetch with two wait states.
      force_wait   = 2;
      mem_store[2] = 32'hA840_0800;
      ref_mem[2]   = 32'hA840_0800;
      i_adr = 32'h0000_0008; i_req = 1'b1;
      do_access(1'b0, 32'h0000_0008, 1'b0, 32'h0, 1'b0, 1'b0);
      check("fetch_rdata_value", i_rdata, 32'hA840_0800);
      force_wait = -1;

      // Load then store.
      mem_store[4] = 32'd82;
      ref_mem[4]   = 32'd82;
      d_adr = 32'h10; d_we = 1'b0; d_wdata = 32'h0; d_req = 1'b1;
      do_access(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
      check("load_rdata_value", d_rdata, 32'd82);
      d_adr = 32'h14; d_we = 1'b1; d_wdata = 32'h55; d_req = 1'b1;
      do_access(1'b1, 32'h14, 1'b1, 32'h55, 1'b0, 1'b0);
      check("store_landed", mem_store[5], 32'h55);

      // Conflicts right after reset: data first, then strict alternation.
      pulse_reset();
      round(2);
      round(2);
      round(2);

      // Reset in the middle of an access drops it with no ready.
      force_wait = 5;
      i_adr = $urandom; i_req = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         seen = mem_req;
      end
      check("mid_rst_req_seen", 32'(seen), 32'd1);
      RESET_N = 1'b0;
      i_req   = 1'b0;
      #1;
      check("mid_rst_mem_req", 32'(mem_req), 32'd0);
      check("mid_rst_i_rdata", i_rdata, 32'h0);
      @(negedge clk);
      RESET_N     = 1'b1;
      model_last  = 1'b0;
      exp_i_rdata = 32'h0;
      exp_d_rdata = 32'h0;
      force_wait  = -1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         check("no_stale_ready", 32'({i_ready, d_ready, mem_req}), 32'd0);
      end
      round(0);

      for (int r = 0; r < 60; r++) round(int'($urandom_range(0, 4)));

`ifdef ARB_TIMEOUT_EN
      // No ack: timeout after TO access cycles with zero data and bus_err.
      force_wait = 20;
      i_adr = $urandom; i_req = 1'b1;
      do_access(1'b0, i_adr, 1'b0, 32'h0, 1'b0, 1'b1);
      // Ack on the last allowed cycle wins over the timeout.
      force_wait = TO - 1;
      i_adr = $urandom; i_req = 1'b1;
      do_access(1'b0, i_adr, 1'b0, 32'h0, 1'b0, 1'b0);
      force_wait = -1;
      round(1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/beta_mem_arbiter.md
Name: beta_mem_arbiter

Overview:
- Shares one single-port word memory between the Beta core's instruction-fetch port (IAdr/D) and its data port (Adr/WD/RD/MOE/MWR).
- Sequences each access with a request/ack handshake to memory and returns one-cycle ready pulses to the requesting port.
- Core stalls on its own while its ready is low.
- Sits between Beta_TOP and the memory model/BRAM wrapper.

Parameters:
- ADDR_W, 16, memory word-address width; mem_adr = adr[ADDR_W+1:2].
- TIMEOUT_CYCLES, 255, ack wait limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held until i_ready.
- i_adr  in  32  fetch byte address (IAdr).
- i_rdata  out  32  fetched instruction (D); valid when i_ready=1.
- i_ready  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request (MOE|MWR); held until d_ready.
- d_we  in  1  1=store (MWR), 0=load (MOE).
- d_adr  in  32  data byte address (Adr).
- d_wdata  in  32  store data (WD).
- d_rdata  out  32  load data (RD); valid when d_ready=1.
- d_ready  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_adr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle.
- bus_err  out  1  one-cycle timeout error pulse; tied 0 without the macro.

Behaviour:
- Reset: while RESET_N=0, all outputs are 0, state=IDLE, last_grant=FETCH, and the timeout counter is 0. Reset is asynchronous. Any in-flight access is dropped with no ready pulse.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request pending: stay in IDLE.
  - One request pending: grant it.
  - Both pending: grant the port not in last_grant, so the first conflict after reset goes to data.
  - On grant, register mem_adr/mem_we/mem_wdata from the granted port, set mem_req=1, update last_grant, go to ACCESS.
  - For fetch, mem_we=0 and mem_wdata=0.
- ACCESS:
  - mem_req and address/data stay stable until mem_ack is sampled high.
  - On mem_ack: mem_req=0, capture mem_rdata into the granted port's rdata register, go to RESP.
  - A store also completes with a ready pulse; d_rdata is then don't-care and is driven with the captured mem_rdata.
- RESP:
  - Assert the granted port's ready for exactly one cycle, then go to IDLE.
  - Requests are ignored in RESP. The requester drops or changes req in the same cycle it samples ready.
- Latency: request seen in cycle N, mem_req high from N+1. With a zero-wait memory (ack in N+1), ready is high in N+2. Throughput is one access per 3 cycles.
- rdata registers hold their value between accesses. Only the granted port's rdata updates.
- Address: low two bits and bits above ADDR_W+1 are discarded, no alignment check. Bit 31 (supervisor) is therefore ignored.
- A request asserted mid-ACCESS by the other port waits. It wins at the next IDLE because of alternation.
- mem_ack while in IDLE or RESP is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - An 8+-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES: mem_req=0, granted rdata=0, go to RESP, and bus_err pulses in the same cycle as the ready pulse.
  - An ack arriving in the same cycle as expiry wins: normal completion, no error.
- Without the macro: no counter, bus_err is constant 0, and ACCESS waits indefinitely.

Decomposition:
- Package beta_mem_pkg holds: state encoding constants (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), grant encoding (GNT_FETCH=1'b0, GNT_DATA=1'b1), and the default TIMEOUT_CYCLES.
- No sub-module is needed. The optional timeout counter stays inline under the macro.

Test Plan:
- Reset: hold RESET_N=0 with i_req=1 → all outputs 0. Release → mem_req=1 with mem_adr=0 one cycle later (i_adr=0x80000000 maps to word 0).
- Single fetch: i_req=1, i_adr=0x00000008, memory acks with 0xA8400800 after 2 wait cycles → mem_adr=2, i_ready pulses once with i_rdata=0xA8400800, d_ready stays 0.
- Load then store: load from d_adr=0x10 returns 82 on d_rdata. Store of d_wdata=0x55 to 0x14 gives mem_we=1, mem_adr=5, mem_wdata=0x55, then d_ready pulses.
- Conflict: i_req and d_req rise together after reset, both held → data served first, then fetch. Repeat with both held → the order keeps alternating.
- Reset mid-ACCESS: assert RESET_N=0 while mem_req=1 → mem_req drops immediately. After release there is no stale ready, and the next request completes normally.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): no ack → after 4 ACCESS cycles mem_req=0, i_ready=1 with i_rdata=0, and bus_err=1 in the same cycle. Ack exactly on cycle 4 → no bus_err.
